// File: rtl/pipe_pkg.sv
// Shared defaults, slot layout and latency helper for the hazard/forwarding scoreboard.
package pipe_pkg;

  localparam int unsigned DEF_RA_W        = 5;
  localparam int unsigned DEF_NUM_SRC     = 2;
  localparam int unsigned DEF_MAX_LAT     = 4;
  localparam int unsigned DEF_FLUSH_DEPTH = 2;
  localparam int unsigned DEF_LAT_W       = 3;
  localparam int unsigned DEF_AGE_W       = $clog2(DEF_FLUSH_DEPTH + 1);

  // One in-flight write in the default configuration.
  typedef struct packed {
    logic                 valid;
    logic [DEF_RA_W-1:0]  rd;
    logic [DEF_AGE_W-1:0] age;
  } slot_t;

  // Map a requested latency onto the legal range 1..max_lat.
  function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned max_lat);
    if (lat == 0) return 1;
    if (lat > max_lat) return max_lat;
    return lat;
  endfunction

endpackage

// File: rtl/sb_src_check.sv
// RAW check for one source operand against every in-flight slot.
module sb_src_check
  import pipe_pkg::*;
#(
  parameter int unsigned RA_W    = DEF_RA_W,
  parameter int unsigned MAX_LAT = DEF_MAX_LAT
) (
  input  logic [RA_W-1:0]         src,
  input  logic [MAX_LAT-1:0]      slot_valid,
  input  logic [MAX_LAT*RA_W-1:0] slot_rd,
  output logic                    raw_stall,
  output logic                    fwd_hit
);

  logic hit0;

  // A younger (j>=1) match must stall even when slot 0 could forward.
  always_comb begin
    raw_stall = 1'b0;
    hit0      = 1'b0;
    for (int unsigned j = 0; j < MAX_LAT; j++) begin
      if (slot_valid[j] && (slot_rd[j*RA_W +: RA_W] == src)) begin
        if (j == 0) hit0 = 1'b1;
        else        raw_stall = 1'b1;
      end
    end
    if (src == '0) begin
      raw_stall = 1'b0;
      hit0      = 1'b0;
    end
    fwd_hit = hit0 & ~raw_stall;
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard between ID and issue: tracks variable-latency writes in a shifting slot pipe.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned RA_W        = DEF_RA_W,
  parameter int unsigned NUM_SRC     = DEF_NUM_SRC,
  parameter int unsigned MAX_LAT     = DEF_MAX_LAT,
  parameter int unsigned FLUSH_DEPTH = DEF_FLUSH_DEPTH,
  parameter int unsigned LAT_W       = DEF_LAT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [NUM_SRC*RA_W-1:0] issue_src,
  input  logic                    issue_we,
  input  logic [RA_W-1:0]         issue_rd,
  input  logic [LAT_W-1:0]        issue_lat,
  input  logic                    flush,
  output logic                    stall,
  output logic [NUM_SRC-1:0]      fwd_hit,
  output logic                    wb_valid,
  output logic [RA_W-1:0]         wb_rd
);

  localparam int unsigned AGE_W = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);

  logic [MAX_LAT-1:0]      slot_valid, valid_nxt;
  logic [RA_W-1:0]         slot_rd  [MAX_LAT];
  logic [RA_W-1:0]         rd_nxt   [MAX_LAT];
  logic [AGE_W-1:0]        slot_age [MAX_LAT];
  logic [AGE_W-1:0]        age_nxt  [MAX_LAT];
  logic [MAX_LAT*RA_W-1:0] rd_flat;
  logic [NUM_SRC-1:0]      raw_vec, fwd_vec;
  logic                    rd_live, waw, structural, accept;
  int unsigned             lat_eff;

  assign lat_eff = clamp_lat(32'(issue_lat), MAX_LAT);
  assign rd_live = issue_we && (issue_rd != '0);

  always_comb begin
    rd_flat = '0;
    for (int unsigned j = 0; j < MAX_LAT; j++) rd_flat[j*RA_W +: RA_W] = slot_rd[j];
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    sb_src_check #(.RA_W(RA_W), .MAX_LAT(MAX_LAT)) u_chk (
      .src        (issue_src[k*RA_W +: RA_W]),
      .slot_valid (slot_valid),
      .slot_rd    (rd_flat),
      .raw_stall  (raw_vec[k]),
      .fwd_hit    (fwd_vec[k])
    );
  end

  // WAW keeps per-register retirement in order; structural avoids two writes landing in one slot.
  always_comb begin
    waw        = 1'b0;
    structural = 1'b0;
    for (int unsigned j = 0; j < MAX_LAT; j++) begin
      if (j >= lat_eff && slot_valid[j] && (slot_rd[j] == issue_rd)) waw = 1'b1;
      if (j == lat_eff && slot_valid[j]) structural = 1'b1;
    end
    waw        = waw & rd_live;
    structural = structural & rd_live;
  end

  assign stall   = issue_valid & ((|raw_vec) | waw | structural);
  assign fwd_hit = issue_valid ? fwd_vec : '0;
  assign accept  = issue_valid & ~stall & ~flush;

  // Shift toward slot 0, age the survivors, then apply flush and the new insert.
  always_comb begin
    valid_nxt = '0;
    for (int unsigned j = 0; j < MAX_LAT; j++) begin
      rd_nxt[j]  = '0;
      age_nxt[j] = '0;
    end
    for (int unsigned j = 0; j + 1 < MAX_LAT; j++) begin
      valid_nxt[j] = slot_valid[j+1];
      rd_nxt[j]    = slot_rd[j+1];
      age_nxt[j]   = (slot_age[j+1] == AGE_W'(FLUSH_DEPTH)) ? slot_age[j+1]
                                                             : slot_age[j+1] + AGE_W'(1);
    end
    if (flush) begin
      for (int unsigned j = 0; j < MAX_LAT; j++) begin
        if (age_nxt[j] < AGE_W'(FLUSH_DEPTH)) begin
          valid_nxt[j] = 1'b0;
          rd_nxt[j]    = '0;
        end
      end
    end
    if (accept && rd_live) begin
      for (int unsigned j = 0; j < MAX_LAT; j++) begin
        if (j + 1 == lat_eff) begin
          valid_nxt[j] = 1'b1;
          rd_nxt[j]    = issue_rd;
          age_nxt[j]   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      for (int unsigned j = 0; j < MAX_LAT; j++) begin
        slot_rd[j]  <= '0;
        slot_age[j] <= '0;
      end
    end else begin
      slot_valid <= valid_nxt;
      for (int unsigned j = 0; j < MAX_LAT; j++) begin
        slot_rd[j]  <= rd_nxt[j];
        slot_age[j] <= age_nxt[j];
      end
    end
  end

  assign wb_valid = slot_valid[0];
  assign wb_rd    = slot_rd[0];

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: retirements predicted by a queue model, hazards by hand.
module tb_pipe_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [9:0] issue_src;
  logic       issue_we;
  logic [4:0] issue_rd;
  logic [2:0] issue_lat;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_hit;
  logic       wb_valid;
  logic [4:0] wb_rd;

  pipe_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_src   (issue_src),
    .issue_we    (issue_we),
    .issue_rd    (issue_rd),
    .issue_lat   (issue_lat),
    .flush       (flush),
    .stall       (stall),
    .fwd_hit     (fwd_hit),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         issue;
    int         due;
    logic [4:0] rd;
  } ent_t;

  ent_t q[$];
  int   cyc;
  int   n_pass;
  int   n_total;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int model_lat(input int lat);
    if (lat < 1) return 1;
    if (lat > 4) return 4;
    return lat;
  endfunction

  // One cycle: drive, check combinational outputs and retirement, update the model, advance.
  task automatic step(input string tag, input logic v, input logic [4:0] s0, input logic [4:0] s1,
                      input logic we, input logic [4:0] rd, input int lat, input logic fl,
                      input logic es, input logic [1:0] ef);
    logic       exp_v;
    logic [4:0] exp_rd;
    issue_valid = v;
    issue_src   = {s1, s0};
    issue_we    = we;
    issue_rd    = rd;
    issue_lat   = 3'(lat);
    flush       = fl;
    @(negedge clk);
    chk({tag, " stall"}, 8'(stall), 8'(es));
    chk({tag, " fwd_hit"}, 8'(fwd_hit), 8'(ef));
    exp_v  = 1'b0;
    exp_rd = '0;
    foreach (q[i]) if (q[i].due == cyc) begin exp_v = 1'b1; exp_rd = q[i].rd; end
    chk({tag, " wb_valid"}, 8'(wb_valid), 8'(exp_v));
    if (exp_v) chk({tag, " wb_rd"}, 8'(wb_rd), 8'(exp_rd));
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) q.delete(i);
      else if (fl && (cyc - q[i].issue) < 2) q.delete(i);
    end
    if (v && !es && !fl && we && rd != 5'd0) q.push_back('{cyc, cyc + model_lat(lat), rd});
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0;
    reset = 1'b1; issue_valid = 1'b0; issue_src = '0; issue_we = 1'b0;
    issue_rd = '0; issue_lat = 3'd1; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst wb_valid", 8'(wb_valid), 8'd0);
    chk("rst wb_rd", 8'(wb_rd), 8'd0);
    chk("rst stall", 8'(stall), 8'd0);
    chk("rst fwd_hit", 8'(fwd_hit), 8'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // latency 3: stall while in flight, forward in the retire cycle
    step("lat3 issue", 1, 0, 0, 1, 5, 3, 0, 0, 2'b00);
    step("lat3 c1",    1, 5, 0, 0, 0, 1, 0, 1, 2'b00);
    step("lat3 c2",    1, 5, 0, 0, 0, 1, 0, 1, 2'b00);
    step("lat3 c3",    1, 5, 0, 0, 0, 1, 0, 0, 2'b01);
    idle("lat3 after");

    // WAW: second rd=7 waits until the first sits in slot 0
    step("waw first", 1, 0, 0, 1, 7, 4, 0, 0, 2'b00);
    step("waw j3",    1, 0, 0, 1, 7, 1, 0, 1, 2'b00);
    step("waw j2",    1, 0, 0, 1, 7, 1, 0, 1, 2'b00);
    step("waw j1",    1, 0, 0, 1, 7, 1, 0, 1, 2'b00);
    step("waw j0",    1, 0, 0, 1, 7, 1, 0, 0, 2'b00);
    idle("waw drain");

    // structural: rd=9 lat=2 collides with rd=8 in slot 2
    step("str first",   1, 0, 0, 1, 8, 3, 0, 0, 2'b00);
    step("str collide", 1, 0, 0, 1, 9, 2, 0, 1, 2'b00);
    step("str retry",   1, 0, 0, 1, 9, 2, 0, 0, 2'b00);
    repeat (3) idle("str drain");

    // flush: young rd=4 and the same-cycle rd=10 die, old rd=3 retires
    step("fl rd3",    1, 0, 0, 1, 3, 4, 0, 0, 2'b00);
    idle("fl gap");
    step("fl rd4",    1, 0, 0, 1, 4, 4, 0, 0, 2'b00);
    step("fl flush",  1, 0, 0, 1, 10, 2, 1, 0, 2'b00);
    step("fl probe",  1, 10, 4, 0, 0, 1, 0, 0, 2'b00);
    repeat (3) idle("fl drain");

    // register 0 is never tracked; mixed r0/r6 sources
    step("r0 issue",  1, 0, 0, 1, 0, 2, 0, 0, 2'b00);
    step("r0 src",    1, 0, 0, 0, 0, 1, 0, 0, 2'b00);
    repeat (2) idle("r0 drain");
    step("ms issue",  1, 0, 0, 1, 6, 3, 0, 0, 2'b00);
    step("ms j2",     1, 0, 6, 0, 0, 1, 0, 1, 2'b00);
    step("ms j1",     1, 0, 6, 0, 0, 1, 0, 1, 2'b00);
    step("ms j0",     1, 0, 6, 0, 0, 1, 0, 0, 2'b10);
    idle("ms after");

    // out-of-range latency clamps to 1 and to MAX_LAT
    step("lat0 issue", 1, 0, 0, 1, 11, 0, 0, 0, 2'b00);
    step("lat0 fwd",   1, 11, 0, 0, 0, 1, 0, 0, 2'b01);
    step("lat7 issue", 1, 0, 0, 1, 12, 7, 0, 0, 2'b00);
    step("lat7 j3",    1, 12, 0, 0, 0, 1, 0, 1, 2'b00);
    repeat (4) idle("lat7 drain");

    // reset with three writes in flight
    step("rs rd13", 1, 0, 0, 1, 13, 4, 0, 0, 2'b00);
    step("rs rd14", 1, 0, 0, 1, 14, 4, 0, 0, 2'b00);
    step("rs rd15", 1, 0, 0, 1, 15, 4, 0, 0, 2'b00);
    idle("rs fill");
    issue_valid = 1'b1;
    issue_src   = {5'd0, 5'd14};
    #1;
    chk("rs pre stall", 8'(stall), 8'd1);
    chk("rs pre wb_valid", 8'(wb_valid), 8'd1);
    reset = 1'b1;
    #1;
    chk("rs now wb_valid", 8'(wb_valid), 8'd0);
    chk("rs now wb_rd", 8'(wb_rd), 8'd0);
    chk("rs now stall", 8'(stall), 8'd0);
    q.delete();
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    repeat (6) idle("rs after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
